// File: rtl/spart.sv
// SPART: a small memory-mapped UART with a programmable baud generator.
// The host sees four byte registers over a shared tri-state bus: the TX/RX
// buffer, a status byte {6'b0, tbr, rda} and the two halves of the 16-bit
// divisor buffer (DB). One tick comes every DB+1 clocks, and one bit time
// is 16 ticks in both directions.
module spart #(
    parameter logic [15:0] DB_RESET = 16'd162
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [1:0] ADDR_BUF    = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    // Bus decode
    logic bus_wr;
    logic bus_rd;
    logic wr_tx;
    logic wr_db_lo;
    logic wr_db_hi;
    logic rd_rx;

    assign bus_wr   = iocs && !iorw;
    assign bus_rd   = iocs && iorw;
    assign wr_tx    = bus_wr && (ioaddr == ADDR_BUF);
    assign wr_db_lo = bus_wr && (ioaddr == ADDR_DB_LO);
    assign wr_db_hi = bus_wr && (ioaddr == ADDR_DB_HI);
    assign rd_rx    = bus_rd && (ioaddr == ADDR_BUF);

    // Divisor buffer and baud counter
    logic [15:0] db;
    logic [15:0] db_next;
    logic [15:0] baud_cnt;
    logic        tick;

    // TX datapath
    tx_state_t   tx_state;
    logic [7:0]  tx_buf;
    logic [3:0]  tx_tick_cnt;
    logic [2:0]  tx_bit_cnt;

    // RX datapath
    rx_state_t   rx_state;
    logic        rxd_meta;
    logic        rxd_sync;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_buf;
    logic [3:0]  rx_tick_cnt;
    logic [2:0]  rx_bit_cnt;

    // Read data mux
    logic [7:0]  rd_data;

    // The DB value as it will look after this cycle's bus write, so the
    // baud counter can be reloaded with the full new divisor on the same edge.
    always_comb begin
        db_next = db;
        if (wr_db_lo) begin
            db_next[7:0] = databus;
        end
        if (wr_db_hi) begin
            db_next[15:8] = databus;
        end
    end

    // Divisor buffer register, written one byte at a time by the host.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db <= DB_RESET;
        end else if (wr_db_lo || wr_db_hi) begin
            db <= db_next;
        end
    end

    // Baud down-counter: a DB write restarts it, otherwise it counts to 0 and reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= DB_RESET;
        end else if (wr_db_lo || wr_db_hi) begin
            baud_cnt <= db_next;
        end else if (baud_cnt == 16'd0) begin
            baud_cnt <= db;
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
        end
    end

    assign tick = (baud_cnt == 16'd0);

    // Transmitter: start bit, 8 data bits LSB first, stop bit, each 16 ticks long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= TX_IDLE;
            tx_buf      <= 8'h00;
            tx_tick_cnt <= 4'd0;
            tx_bit_cnt  <= 3'd0;
            txd         <= 1'b1;
            tbr         <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    txd <= 1'b1;
                    if (wr_tx && tbr) begin
                        tx_buf      <= databus;
                        tbr         <= 1'b0;
                        txd         <= 1'b0;
                        tx_tick_cnt <= 4'd0;
                        tx_bit_cnt  <= 3'd0;
                        tx_state    <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                        if (tx_tick_cnt == 4'd15) begin
                            txd        <= tx_buf[0];
                            tx_bit_cnt <= 3'd0;
                            tx_state   <= TX_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                        if (tx_tick_cnt == 4'd15) begin
                            if (tx_bit_cnt == 3'd7) begin
                                txd      <= 1'b1;
                                tx_state <= TX_STOP;
                            end else begin
                                txd        <= tx_buf[tx_bit_cnt + 3'd1];
                                tx_bit_cnt <= tx_bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        tx_tick_cnt <= tx_tick_cnt + 4'd1;
                        if (tx_tick_cnt == 4'd15) begin
                            tbr      <= 1'b1;
                            tx_state <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    txd      <= 1'b1;
                    tbr      <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // Two-flop synchronizer: rxd is asynchronous and must not reach the FSM directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    // Receiver: qualify the start bit at mid-bit, then sample every 16 ticks;
    // a completed byte setting rda is written last so it wins over a same-edge read clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state    <= RX_IDLE;
            rx_shift    <= 8'h00;
            rx_buf      <= 8'h00;
            rx_tick_cnt <= 4'd0;
            rx_bit_cnt  <= 3'd0;
            rda         <= 1'b0;
        end else begin
            if (rd_rx) begin
                rda <= 1'b0;
            end
            case (rx_state)
                RX_IDLE: begin
                    if (tick && !rxd_sync) begin
                        rx_tick_cnt <= 4'd0;
                        rx_state    <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        if (rx_tick_cnt == 4'd7) begin
                            rx_tick_cnt <= 4'd0;
                            rx_bit_cnt  <= 3'd0;
                            if (!rxd_sync) begin
                                rx_state <= RX_DATA;
                            end else begin
                                rx_state <= RX_IDLE;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        if (rx_tick_cnt == 4'd15) begin
                            rx_shift   <= {rxd_sync, rx_shift[7:1]};
                            rx_bit_cnt <= rx_bit_cnt + 3'd1;
                            if (rx_bit_cnt == 3'd7) begin
                                rx_state <= RX_STOP;
                            end
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        if (rx_tick_cnt == 4'd15) begin
                            rx_state <= RX_IDLE;
                            if (rxd_sync) begin
                                rx_buf <= rx_shift;
                                rda    <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end

    // Register read mux for host reads.
    always_comb begin
        rd_data = 8'h00;
        case (ioaddr)
            ADDR_BUF:    rd_data = rx_buf;
            ADDR_STATUS: rd_data = {6'b000000, tbr, rda};
            ADDR_DB_LO:  rd_data = db[7:0];
            ADDR_DB_HI:  rd_data = db[15:8];
            default:     rd_data = 8'h00;
        endcase
    end

    assign databus = bus_rd ? rd_data : 8'bzzzzzzzz;

endmodule

// File: tb/tb_spart.sv
// Testbench for spart: directed bus/serial stimulus, a timing model of the
// transmitter derived from the baud arithmetic, and literal expectations.
module tb_spart;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic [7:0] bus_drv = 8'h00;
    logic       bus_drv_en = 1'b0;
    wire  [7:0] databus;
    logic       rda;
    logic       tbr;
    logic       txd;
    logic       rxd;
    logic       rxd_drv = 1'b1;
    logic       loopback = 1'b0;

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Transmitter model: frame loaded at edge frame_l, ticks at edges
    // tick_r + k*tick_p (k >= 1) since the last divisor write.
    bit         cmp_en = 1'b0;
    bit         frame_valid = 1'b0;
    int         frame_l = 0;
    int         tick_r = 0;
    int         tick_p = 163;
    logic [7:0] frame_byte = 8'h00;
    logic [15:0] model_db = 16'd162;

    assign databus = bus_drv_en ? bus_drv : 8'bzzzzzzzz;
    assign rxd = loopback ? txd : rxd_drv;

    spart #(.DB_RESET(16'd162)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .databus (databus),
        .rda     (rda),
        .tbr     (tbr),
        .txd     (txd),
        .rxd     (rxd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int ticks_between(input int from_e, input int to_e);
        return ((to_e - tick_r) / tick_p) - ((from_e - tick_r) / tick_p);
    endfunction

    function automatic logic exp_txd(input int n);
        int t;
        if (!frame_valid) return 1'b1;
        t = ticks_between(frame_l, n);
        if (t < 16) return 1'b0;
        if (t < 144) return frame_byte[3'((t - 16) / 16)];
        return 1'b1;
    endfunction

    function automatic logic exp_tbr(input int n);
        if (!frame_valid) return 1'b1;
        return (ticks_between(frame_l, n) >= 160) ? 1'b1 : 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One bus cycle starting at a negedge; returns read data and the edge it used.
    task automatic applyStimulus(input logic rw, input logic [1:0] addr, input logic [7:0] wdata,
                                 output logic [7:0] rdata, output int edge_idx);
        iocs   = 1'b1;
        iorw   = rw;
        ioaddr = addr;
        if (!rw) begin
            bus_drv    = wdata;
            bus_drv_en = 1'b1;
        end
        #1 rdata = databus;
        @(posedge clk);
        @(negedge clk);
        edge_idx   = edge_n - 1;
        iocs       = 1'b0;
        iorw       = 1'b0;
        bus_drv_en = 1'b0;
        if (!rw) begin
            case (addr)
                2'b00: begin
                    if (exp_tbr(edge_idx - 1)) begin
                        frame_valid = 1'b1;
                        frame_l     = edge_idx;
                        frame_byte  = wdata;
                    end
                end
                2'b10: begin
                    model_db[7:0] = wdata;
                    tick_p = int'(model_db) + 1;
                    tick_r = edge_idx;
                end
                2'b11: begin
                    model_db[15:8] = wdata;
                    tick_p = int'(model_db) + 1;
                    tick_r = edge_idx;
                end
                default: ;
            endcase
        end
    endtask

    task automatic wait_until_edge(input int target);
        while (edge_n - 1 < target) @(negedge clk);
    endtask

    task automatic send_rx_frame(input logic [7:0] b, input logic stop_bit, input int bit_clks);
        rxd_drv = 1'b0;
        repeat (bit_clks) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = b[i];
            repeat (bit_clks) @(negedge clk);
        end
        rxd_drv = stop_bit;
        repeat (bit_clks) @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    // Compare txd/tbr against the transmitter model on every cycle.
    always @(negedge clk) begin
        if (cmp_en) begin
            #2;
            checkOutput("txd_model", 16'(txd), 16'(exp_txd(edge_n - 1)));
            checkOutput("tbr_model", 16'(tbr), 16'(exp_tbr(edge_n - 1)));
        end
    end

    // Directed scenario sequence.
    initial begin
        logic [7:0] rd;
        int         e;
        int         l_a5;
        int         k;
        logic       exp_a5 [0:9];
        exp_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        checkOutput("reset_txd", 16'(txd), 16'd1);
        checkOutput("reset_tbr", 16'(tbr), 16'd1);
        checkOutput("reset_rda", 16'(rda), 16'd0);
        applyStimulus(1'b1, 2'b01, 8'h00, rd, e);
        checkOutput("reset_status", 16'(rd), 16'h02);
        applyStimulus(1'b1, 2'b10, 8'h00, rd, e);
        checkOutput("reset_db_lo", 16'(rd), 16'hA2);
        applyStimulus(1'b1, 2'b11, 8'h00, rd, e);
        checkOutput("reset_db_hi", 16'(rd), 16'h00);
        applyStimulus(1'b1, 2'b00, 8'h00, rd, e);
        checkOutput("reset_rxbuf", 16'(rd), 16'h00);

        // DB = 3, then send A5 aligned to a tick so every bit is exactly 64 clocks
        applyStimulus(1'b0, 2'b10, 8'h03, rd, e);
        applyStimulus(1'b0, 2'b11, 8'h00, rd, e);
        applyStimulus(1'b1, 2'b10, 8'h00, rd, e);
        checkOutput("db_lo_readback", 16'(rd), 16'h03);
        wait_until_edge(tick_r + 3);
        applyStimulus(1'b0, 2'b00, 8'hA5, rd, l_a5);
        checkOutput("tbr_low_after_load", 16'(tbr), 16'd0);
        for (int b = 0; b < 10; b++) begin
            wait_until_edge(l_a5 + 32 + 64 * b);
            checkOutput("a5_bit", 16'(txd), 16'(exp_a5[b]));
            if (b == 1) begin
                applyStimulus(1'b0, 2'b00, 8'h11, rd, e);
            end
        end
        wait_until_edge(l_a5 + 639);
        checkOutput("tbr_before_end", 16'(tbr), 16'd0);
        wait_until_edge(l_a5 + 640);
        checkOutput("tbr_after_stop", 16'(tbr), 16'd1);
        checkOutput("txd_idle", 16'(txd), 16'd1);

        // Loopback 3C
        loopback = 1'b1;
        applyStimulus(1'b0, 2'b00, 8'h3C, rd, e);
        k = 0;
        while (rda !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        checkOutput("loop_rda_set", 16'(rda), 16'd1);
        k = 0;
        while (tbr !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
        checkOutput("loop_tbr_back", 16'(tbr), 16'd1);
        applyStimulus(1'b1, 2'b01, 8'h00, rd, e);
        checkOutput("loop_status", 16'(rd), 16'h03);
        applyStimulus(1'b1, 2'b00, 8'h00, rd, e);
        checkOutput("loop_rxbuf", 16'(rd), 16'h3C);
        checkOutput("loop_rda_clear", 16'(rda), 16'd0);
        loopback = 1'b0;
        repeat (20) @(negedge clk);

        // False start: 4 ticks low only
        rxd_drv = 1'b0;
        repeat (16) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("false_start_rda", 16'(rda), 16'd0);

        // Framing error on FF
        send_rx_frame(8'hFF, 1'b0, 64);
        repeat (300) @(negedge clk);
        checkOutput("framing_rda", 16'(rda), 16'd0);
        applyStimulus(1'b1, 2'b00, 8'h00, rd, e);
        checkOutput("framing_rxbuf", 16'(rd), 16'h3C);

        // Valid frame, then overrun with a second frame
        send_rx_frame(8'h5A, 1'b1, 64);
        checkOutput("rx_5a_rda", 16'(rda), 16'd1);
        applyStimulus(1'b1, 2'b00, 8'h00, rd, e);
        checkOutput("rx_5a_data", 16'(rd), 16'h5A);
        send_rx_frame(8'hC3, 1'b1, 64);
        send_rx_frame(8'h96, 1'b1, 64);
        checkOutput("overrun_rda", 16'(rda), 16'd1);
        applyStimulus(1'b1, 2'b00, 8'h00, rd, e);
        checkOutput("overrun_data", 16'(rd), 16'h96);
        checkOutput("overrun_rda_clear", 16'(rda), 16'd0);

        // Reset pulse in the middle of a frame
        applyStimulus(1'b0, 2'b00, 8'h81, rd, e);
        repeat (200) @(negedge clk);
        checkOutput("mid_tx_tbr_busy", 16'(tbr), 16'd0);
        #3;
        frame_valid = 1'b0;
        model_db    = 16'd162;
        rst_n       = 1'b0;
        #1;
        checkOutput("async_rst_txd", 16'(txd), 16'd1);
        checkOutput("async_rst_tbr", 16'(tbr), 16'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (400) @(negedge clk);
        applyStimulus(1'b1, 2'b10, 8'h00, rd, e);
        checkOutput("post_rst_db_lo", 16'(rd), 16'hA2);
        applyStimulus(1'b1, 2'b11, 8'h00, rd, e);
        checkOutput("post_rst_db_hi", 16'(rd), 16'h00);
        applyStimulus(1'b1, 2'b01, 8'h00, rd, e);
        checkOutput("post_rst_status", 16'(rd), 16'h02);

        cmp_en = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spart.md
SPART -- requirements
Module: spart

Interface
REQ-001 SHALL provide parameter DB_RESET, default 16'd162: divisor-buffer reset value (50 MHz clk, 19200 baud, 16x oversampling).
REQ-002 SHALL have clk, input, 1: clock; all state updates on rising edge.
REQ-003 SHALL have rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have iocs, input, 1: chip select; bus access only when high.
REQ-005 SHALL have iorw, input, 1: 1 = read from SPART, 0 = write to SPART.
REQ-006 SHALL have ioaddr, input, 2: register select (00 TX/RX buffer, 01 status, 10 DB low, 11 DB high).
REQ-007 SHALL have databus, inout, 8: shared bidirectional data bus.
REQ-008 SHALL have rda, output, 1: receive data available.
REQ-009 SHALL have tbr, output, 1: transmit buffer ready.
REQ-010 SHALL have txd, output, 1: serial transmit line, idle high.
REQ-011 SHALL have rxd, input, 1: serial receive line, asynchronous, idle high.

Function
REQ-012 Bus write (iocs=1, iorw=0) SHALL take effect at the clock edge it is present: addr 00 loads TX buffer, 10 loads DB[7:0], 11 loads DB[15:8], 01 ignored.
REQ-013 Bus read (iocs=1, iorw=1) SHALL drive databus combinationally: 00 RX buffer, 01 {6'b0, tbr, rda}, 10 DB[7:0], 11 DB[15:8]; otherwise databus SHALL be high-Z.
REQ-014 Baud generator SHALL be a 16-bit down-counter; at 0 it asserts one-cycle tick and reloads DB, so tick period = DB+1 clk cycles.
REQ-015 Write to DB low or DB high SHALL also reload the counter with the new 16-bit DB value on the same edge.
REQ-016 One bit time SHALL equal 16 ticks for both TX and RX.
REQ-017 TX FSM states: IDLE, START, DATA, STOP; a write to addr 00 while tbr=1 SHALL load the buffer, clear tbr next cycle, and enter START.
REQ-018 Write to addr 00 while tbr=0 SHALL be ignored; in-progress frame unaffected.
REQ-019 TX frame SHALL be start bit 0, data bits LSB first, stop bit 1, each held 16 ticks; tbr SHALL reassert in the cycle after the stop bit's 16th tick, returning to IDLE.
REQ-020 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-021 RX FSM states: IDLE, START, DATA, STOP; IDLE SHALL enter START on the synchronized rxd being 0 at a tick.
REQ-022 In START, after 8 ticks rxd SHALL be resampled: 0 enters DATA, 1 returns to IDLE (false start, no flags change).
REQ-023 DATA SHALL sample each of 8 bits at 16-tick intervals from mid-start, shifting LSB first.
REQ-024 STOP SHALL sample after 16 more ticks: 1 loads RX buffer and sets rda; 0 (framing error) discards byte, rda and RX buffer unchanged; both return to IDLE.
REQ-025 Read of addr 00 SHALL clear rda at that edge; if a byte completes on the same edge, set wins (rda=1, new data).
REQ-026 A completed byte while rda=1 SHALL overwrite the RX buffer (overrun, no flag).
REQ-027 TX and RX SHALL operate independently and concurrently from the shared tick.

Reset
REQ-028 On rst_n low: txd=1, tbr=1, rda=0, TX/RX FSMs IDLE, TX/RX buffers 8'h00, DB=DB_RESET, counter=DB_RESET, databus high-Z.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately; txd=1 with no partial bits resumed after release.

Verification
REQ-030 DB=16'd3 written, write 8'hA5 to addr 00 -> tbr low next cycle; txd 0, 1,0,1,0,0,1,0,1, 1, each 64 clk; tbr high after.
REQ-031 Loop txd to rxd, DB=3, send 8'h3C -> rda=1 after stop; read addr 00 returns 8'h3C and rda=0 next cycle.
REQ-032 rxd 0-pulse of 4 ticks only -> no rda, RX FSM back to IDLE.
REQ-033 Frame with stop bit 0 (data 8'hFF) -> rda stays 0, RX buffer unchanged.
REQ-034 Second write to addr 00 during active TX with 8'h11 -> ignored; transmitted byte equals first.
REQ-035 Read addr 01 at reset -> 8'h02; addr 10/11 -> DB_RESET bytes (8'hA2, 8'h00); rst_n pulse mid-TX -> txd=1, tbr=1 immediately.
